alu_wide_seq: RTL and testbench
===============================

# alu_wide_seq

Multi-word arithmetic sequencer that drives the existing N-bit `alu` as its initiator and consumes its result and flag outputs. It performs a WORDS×N-bit add, add-with-carry, subtract or subtract-with-borrow by issuing one ALU word operation per cycle, least-significant word first, and chains `cout` into the next `cin`. It returns the wide result and aggregate flags over a valid/ready handshake. The `alu` instance lives beside this block at the datapath level and is connected through the `alu_*` ports.

## Interface
- `N`, 8: ALU word width; must match the attached `alu` instance.
- `WORDS`, 4: number of words per operand (≥2); the wide width is W = N*WORDS.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  command valid
- `in_ready`  out  1  block can accept a command
- `in_a`, `in_b`  in  W  wide operands
- `in_sub`  in  1  1 = subtract: B words are bitwise inverted before issue
- `in_cin`  in  1  initial carry into word 0 (set to 1 for a plain subtract)
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts the result
- `out_result`  out  W  wide result
- `out_carry`, `out_overflow`, `out_sign`, `out_zero`  out  1 each  aggregate flags
- `alu_a`, `alu_b`  out  N  ALU operands
- `alu_op`  out  7  ALU opcode; always `` `ALU_ADD ``
- `alu_cin`  out  1  ALU carry in
- `alu_out`  in  N  ALU result (combinational from `alu_*` outputs)
- `alu_cout`, `alu_overflow`, `alu_sign`, `alu_zero`  in  1 each  ALU flags

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `in_ready`=1. When `in_valid`&`in_ready`:
  - latch `in_a`; latch `in_b`, XORed with all-ones if `in_sub`;
  - carry register ← `in_cin`; idx ← 0; zero accumulator ← 1;
  - go to RUN.
- RUN: `in_ready`=0.
  - Drive `alu_a` = A word[idx] (bits idx*N+N-1 : idx*N), `alu_b` = B' word[idx], `alu_cin` = carry register.
  - At the clock edge: result word[idx] ← `alu_out`; carry register ← `alu_cout`; zero accumulator ← accumulator & `alu_zero`; idx ← idx+1.
  - When idx = WORDS-1, also capture `out_overflow` ← `alu_overflow` and `out_sign` ← `alu_sign`, then go to DONE.
- DONE: `out_valid`=1.
  - `out_carry` = final carry register. This is the raw cout, so for subtract 1 means no borrow.
  - `out_zero` = zero accumulator.
  - On `out_valid`&`out_ready`, return to IDLE.
- The new command is accepted no earlier than the cycle after DONE exits. There is no same-cycle pass-through from DONE to accept.
- Outside RUN: `alu_a`=0, `alu_b`=0, `alu_cin`=0. `alu_op` is always `` `ALU_ADD ``.
- `out_result` and the flags hold their last values in IDLE and RUN. Consumers qualify them with `out_valid` only.
- Commands arriving while `in_ready`=0 are ignored and not queued.
- The ALU signed overflow of the most-significant word, computed with its carry in, is the wide signed overflow. The block does no extra overflow math.

## Timing
- Reset values: state IDLE; `in_ready`=1 from the first cycle after reset; `out_valid`=0; `out_result`=0; all flags 0; idx=0; carry register 0; `alu_*` outputs at their idle values.
- Latency: accept at edge 0, RUN for edges 1..WORDS, `out_valid` high in the cycle after edge WORDS. With WORDS=4, `out_valid` rises 4 cycles after the accept edge.
- Throughput: one command per WORDS+2 cycles when `out_ready` is held high.
- Backpressure: `out_valid`, `out_result` and the flags stay stable while `out_ready`=0. `in_ready` stays 0 throughout.
- `rst` in any state (including mid-RUN) returns all registers to their reset values at that edge. A partial result is discarded and never presented.
- idx never exceeds WORDS-1. There is no wrap into a second pass.

## Test plan
All cases use N=8, WORDS=4.
- Reset: hold `rst` 2 cycles → `in_ready`=1, `out_valid`=0, `out_result`=0x00000000, all flags 0, `alu_cin`=0.
- Add with carry propagation: A=0x000000FF, B=0x00000001, sub=0, cin=0 → result 0x00000100, carry=0, zero=0, sign=0, overflow=0. `out_valid` rises exactly 4 cycles after accept. `alu_cin` = 0, 1, 0, 0 across the RUN cycles.
- Full wrap: A=0xFFFFFFFF, B=0x00000001 → result 0x00000000, carry=1, zero=1, sign=0, overflow=0.
- Signed overflow: A=0x7FFFFFFF, B=0x00000001 → result 0x80000000, overflow=1, sign=1, carry=0, zero=0.
- Subtract with backpressure: A=5, B=7, sub=1, cin=1 → result 0xFFFFFFFE, carry=0, sign=1, zero=0.
  - Hold `out_ready`=0 for 3 cycles → outputs stable and `in_ready`=0.
  - Pulse `in_valid` during the stall → command ignored.
  - Release `out_ready` → IDLE the next cycle.
- Reset mid-operation: assert `rst` after 2 RUN cycles of A=0x01020304 + B=0x01010101 → `out_valid` never rises and `in_ready`=1 the next cycle. A fresh 0x01020304 + 0x01010101 then yields 0x02030405 with carry=0.

Source files
------------

// File: rtl/alu_wide_seq.sv
// Multi-word add/sub sequencer: drives an external N-bit ALU one word
// per cycle, LSW first, chaining carry, and returns a wide result.
`ifndef ALU_ADD
`define ALU_ADD 7'h00
`endif

module alu_wide_seq #(
   parameter int N     = 8,
   parameter int WORDS = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [N*WORDS-1:0] i_in_a,
   input  logic [N*WORDS-1:0] i_in_b,
   input  logic             i_in_sub,
   input  logic             i_in_cin,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [N*WORDS-1:0] o_out_result,
   output logic             o_out_carry,
   output logic             o_out_overflow,
   output logic             o_out_sign,
   output logic             o_out_zero,
   output logic [N-1:0]     o_alu_a,
   output logic [N-1:0]     o_alu_b,
   output logic [6:0]       o_alu_op,
   output logic             o_alu_cin,
   input  logic [N-1:0]     i_alu_out,
   input  logic             i_alu_cout,
   input  logic             i_alu_overflow,
   input  logic             i_alu_sign,
   input  logic             i_alu_zero
);

   localparam int W  = N * WORDS;
   localparam int IW = $clog2(WORDS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [W-1:0]    r_a;
   logic [W-1:0]    r_b;
   logic [W-N-1:0]  r_part;
   logic [W-1:0]    r_res;
   logic [IW-1:0]   r_idx;
   logic            r_carry;
   logic            r_zacc;
   logic            r_cflag;
   logic            r_vflag;
   logic            r_sflag;
   logic            r_zflag;
   logic            w_last;
   logic            w_accept;

   assign w_last   = (r_idx == IW'(WORDS - 1));
   assign w_accept = (r_state == S_IDLE) && i_in_valid;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      o_in_ready  = 1'b0;
      o_out_valid = 1'b0;
      o_alu_a     = '0;
      o_alu_b     = '0;
      o_alu_cin   = 1'b0;
      o_alu_op    = `ALU_ADD;
      unique case (r_state)
         S_IDLE: begin
            o_in_ready = 1'b1;
            if (i_in_valid) w_next = S_RUN;
         end
         S_RUN: begin
            o_alu_a   = r_a[r_idx*N +: N];
            o_alu_b   = r_b[r_idx*N +: N];
            o_alu_cin = r_carry;
            if (w_last) w_next = S_DONE;
         end
         S_DONE: begin
            o_out_valid = 1'b1;
            if (i_out_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Working words build in r_part; visible outputs update only on the last word
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_part  <= '0;
         r_res   <= '0;
         r_idx   <= '0;
         r_carry <= 1'b0;
         r_zacc  <= 1'b0;
         r_cflag <= 1'b0;
         r_vflag <= 1'b0;
         r_sflag <= 1'b0;
         r_zflag <= 1'b0;
      end else if (w_accept) begin
         r_a     <= i_in_a;
         r_b     <= i_in_b ^ {W{i_in_sub}};
         r_carry <= i_in_cin;
         r_idx   <= '0;
         r_zacc  <= 1'b1;
      end else if (r_state == S_RUN) begin
         r_carry <= i_alu_cout;
         r_zacc  <= r_zacc & i_alu_zero;
         if (w_last) begin
            r_idx   <= '0;
            r_res   <= {i_alu_out, r_part};
            r_cflag <= i_alu_cout;
            r_vflag <= i_alu_overflow;
            r_sflag <= i_alu_sign;
            r_zflag <= r_zacc & i_alu_zero;
         end else begin
            r_idx <= r_idx + 1'b1;
            r_part[r_idx*N +: N] <= i_alu_out;
         end
      end
   end

   assign o_out_result   = r_res;
   assign o_out_carry    = r_cflag;
   assign o_out_overflow = r_vflag;
   assign o_out_sign     = r_sflag;
   assign o_out_zero     = r_zflag;

endmodule

// File: tb/tb_alu_wide_seq.sv
// Directed bench for alu_wide_seq with a behavioural 8-bit ALU beside it.
module tb_alu_wide_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        in_sub;
   logic        in_cin;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_carry;
   logic        out_overflow;
   logic        out_sign;
   logic        out_zero;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [6:0]  alu_op;
   logic        alu_cin;
   logic [7:0]  alu_out;
   logic        alu_cout;
   logic        alu_overflow;
   logic        alu_sign;
   logic        alu_zero;

   int nvec = 0;
   int nfail = 0;
   int lat;
   logic [3:0] cins;

   always #5 clk = ~clk;

   always_comb begin
      {alu_cout, alu_out} = {1'b0, alu_a} + {1'b0, alu_b}
                          + {8'd0, alu_cin};
      alu_overflow = (alu_a[7] == alu_b[7]) && (alu_out[7] != alu_a[7]);
      alu_sign     = alu_out[7];
      alu_zero     = (alu_out == 8'd0);
   end

   alu_wide_seq #(.N(8), .WORDS(4)) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_in_valid     (in_valid),
      .o_in_ready     (in_ready),
      .i_in_a         (in_a),
      .i_in_b         (in_b),
      .i_in_sub       (in_sub),
      .i_in_cin       (in_cin),
      .o_out_valid    (out_valid),
      .i_out_ready    (out_ready),
      .o_out_result   (out_result),
      .o_out_carry    (out_carry),
      .o_out_overflow (out_overflow),
      .o_out_sign     (out_sign),
      .o_out_zero     (out_zero),
      .o_alu_a        (alu_a),
      .o_alu_b        (alu_b),
      .o_alu_op       (alu_op),
      .o_alu_cin      (alu_cin),
      .i_alu_out      (alu_out),
      .i_alu_cout     (alu_cout),
      .i_alu_overflow (alu_overflow),
      .i_alu_sign     (alu_sign),
      .i_alu_zero     (alu_zero)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Accept a command, then count edges until out_valid (bounded)
   task automatic run(input logic [31:0] a, input logic [31:0] b,
                      input logic sub, input logic cin);
      in_a = a;
      in_b = b;
      in_sub = sub;
      in_cin = cin;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      lat = 0;
      cins = '0;
      while (!out_valid && lat < 20) begin
         if (lat < 4) cins[lat] = alu_cin;
         step();
         lat++;
      end
      chk("latency", 32'(lat), 32'd4);
   endtask

   task automatic flags(input string tag, input logic [31:0] r,
                        input logic c, input logic v,
                        input logic s, input logic z);
      chk({tag, "_res"}, out_result, r);
      chk({tag, "_c"}, 32'(out_carry), 32'(c));
      chk({tag, "_v"}, 32'(out_overflow), 32'(v));
      chk({tag, "_s"}, 32'(out_sign), 32'(s));
      chk({tag, "_z"}, 32'(out_zero), 32'(z));
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      in_a = '0;
      in_b = '0;
      in_sub = 1'b0;
      in_cin = 1'b0;
      out_ready = 1'b1;
      step();
      step();
      rst = 1'b0;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      flags("rst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rst_alu_cin", 32'(alu_cin), 32'd0);
      chk("rst_alu_a", 32'(alu_a), 32'd0);

      run(32'h000000FF, 32'h00000001, 1'b0, 1'b0);
      chk("add_cins", 32'(cins), 32'b0010);
      flags("add", 32'h00000100, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("add_busy", 32'(in_ready), 32'd0);
      step();
      chk("add_idle", 32'(in_ready), 32'd1);
      chk("add_nov", 32'(out_valid), 32'd0);

      run(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
      flags("wrap", 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1);
      step();

      run(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
      flags("ovf", 32'h80000000, 1'b0, 1'b1, 1'b1, 1'b0);
      step();

      out_ready = 1'b0;
      run(32'd5, 32'd7, 1'b1, 1'b1);
      flags("sub", 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         in_valid = (i == 1);
         in_a = 32'h11111111;
         in_b = 32'h22222222;
         in_sub = 1'b0;
         in_cin = 1'b0;
         step();
         chk("stall_valid", 32'(out_valid), 32'd1);
         chk("stall_ready", 32'(in_ready), 32'd0);
         chk("stall_res", out_result, 32'hFFFFFFFE);
         chk("stall_s", 32'(out_sign), 32'd1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      chk("rel_idle", 32'(in_ready), 32'd1);
      chk("rel_nov", 32'(out_valid), 32'd0);
      step();
      chk("ignored_cmd", 32'(in_ready), 32'd1);

      in_a = 32'h01020304;
      in_b = 32'h01010101;
      in_sub = 1'b0;
      in_cin = 1'b0;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_res", out_result, 32'h0);
      for (int i = 0; i < 6; i++) begin
         chk("mid_rst_nov", 32'(out_valid), 32'd0);
         step();
      end
      run(32'h01020304, 32'h01010101, 1'b0, 1'b0);
      flags("fresh", 32'h02030405, 1'b0, 1'b0, 1'b0, 1'b0);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
